muldiv_ctrl: RTL and testbench

- Sequences the multi-cycle multiply/divide resource beside the EX stage and owns the architectural HI/LO registers.
- Accepts one MD operation from EX per start pulse and models fixed MIPS latencies: MULT/MULTU 5 cycles, DIV/DIVU 10 cycles.
- Holds busy while an operation runs and raises a pipeline stall request whenever ID holds an MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo) during or at the start of an operation.

---
 rtl/muldiv_ctrl.sv | 109 ++++++++++
 tb/tb_muldiv_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer beside EX: owns HI/LO, models fixed MULT/DIV latencies
// and raises a stall request while ID holds an MD-class instruction.
module muldiv_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        id_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Explicit widening keeps the low 64 bits of the product correct for both signednesses.
    assign w_prod = r_op[0] ? ({32'd0, r_a} * {32'd0, r_b})
                            : ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b});

    // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000.
    assign w_a_neg = (r_op == 2'd2) && r_a[31];
    assign w_b_neg = (r_op == 2'd2) && r_b[31];
    assign w_a_mag = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_b_mag = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;
    assign w_quo   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_a     <= src_a;
                                r_b     <= src_b;
                                r_op    <= md_op[1:0];
                                r_cnt   <= md_op[1] ? DIV_CNT : MULT_CNT;
                                r_state <= ST_RUN;
                            end
                            3'd4:    r_hi <= src_a;
                            3'd5:    r_lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (r_cnt > 4'd1) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        if (!r_op[1]) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_b != 32'd0) begin
                            // Divide by zero leaves HI/LO untouched.
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
            endcase
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign stall = id_md & (busy | (start & (md_op <= 3'd3)));
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO and
// latency, a monitor pops on each completion.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd7;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        id_md = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .id_md(id_md),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_move;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          illegal_starts = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: plain arithmetic on the architectural rules.
    function automatic exp_t model_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb2, p;
        longint unsigned ua, ub, up;
        int q, r;
        e.is_move = 1'b0;
        e.hi = m_hi;
        e.lo = m_lo;
        e.lat = (op < 3'd2) ? 5 : 10;
        sa = $signed(a);
        sb2 = $signed(b);
        ua = a;
        ub = b;
        case (op)
            3'd0: begin p = sa * sb2; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
            3'd2: if (b != 0) begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.lo = 32'h80000000; e.hi = 32'h0;
                end else begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    e.lo = q; e.hi = r;
                end
            end
            default: if (b != 0) begin
                e.lo = a / b; e.hi = a % b;
            end
        endcase
        return e;
    endfunction

    // Monitor: completion is the falling edge of busy; moves are checked one cycle after issue.
    initial begin
        int   busy_run;
        bit   mv_pending;
        exp_t e;
        busy_run = 0;
        mv_pending = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run = 0;
                mv_pending = 0;
            end else begin
                if (mv_pending) begin
                    mv_pending = 0;
                    if (sb.size() == 0 || !sb[0].is_move) begin
                        check("move_expected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("move_hi", {32'd0, hi}, {32'd0, e.hi});
                        check("move_lo", {32'd0, lo}, {32'd0, e.lo});
                        check("move_busy", {63'd0, busy}, 64'd0);
                    end
                end
                if (busy) begin
                    busy_run++;
                    if (start) illegal_starts++;
                end else begin
                    if (busy_run > 0) begin
                        if (sb.size() == 0 || sb[0].is_move) begin
                            check("unexpected_completion", 64'd1, 64'd0);
                        end else begin
                            e = sb.pop_front();
                            check("latency", 64'(busy_run), 64'(e.lat));
                            check("res_hi", {32'd0, hi}, {32'd0, e.hi});
                            check("res_lo", {32'd0, lo}, {32'd0, e.lo});
                        end
                    end
                    busy_run = 0;
                    if (start && (md_op == 3'd4 || md_op == 3'd5)) mv_pending = 1;
                end
            end
        end
    end

    // Called right after a posedge; returns right after the posedge following completion.
    task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic id);
        exp_t e;
        int   lat;
        int   waited;
        e = model_arith(op, a, b);
        lat = e.lat;
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        start = 1'b1; md_op = op; src_a = a; src_b = b; id_md = id;
        @(negedge clk);
        check("stall_start", {63'd0, stall}, {63'd0, id});
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7; src_a = $urandom; src_b = $urandom;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("stall_busy%0d", k), {63'd0, stall}, {63'd0, id});
            if (k < lat) begin
                @(posedge clk); #1;
                src_a = $urandom; src_b = $urandom;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_after", {63'd0, stall}, 64'd0);
        waited = 0;
        while (busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        id_md = 1'b0;
    endtask

    task automatic run_move(input logic [2:0] op, input logic [31:0] a, input logic id);
        exp_t e;
        e.is_move = 1'b1;
        e.lat = 0;
        if (op == 3'd4) m_hi = a; else m_lo = a;
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        start = 1'b1; md_op = op; src_a = a; src_b = $urandom; id_md = id;
        @(negedge clk);
        check("stall_move", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7; id_md = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_noop(input logic [2:0] op);
        start = 1'b1; md_op = op; src_a = $urandom; src_b = $urandom;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7;
        @(negedge clk);
        check("noop_hi", {32'd0, hi}, {32'd0, m_hi});
        check("noop_lo", {32'd0, lo}, {32'd0, m_lo});
        check("noop_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] op;
        exp_t e;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        run_arith(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1);
        run_arith(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_arith(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_arith(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_move(3'd4, 32'h12345678, 1'b1);
        run_arith(3'd3, 32'd7, 32'd0, 1'b0);
        run_noop(3'd6);

        // Reset in busy cycle 3 of a DIV aborts it with no late write.
        e = model_arith(3'd2, 32'd100, 32'd7);
        sb.push_back(e);
        start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("late_hi", {32'd0, hi}, 64'd0);
        check("late_lo", {32'd0, lo}, 64'd0);
        @(posedge clk); #1;

        // Start while running is ignored; only the first operation's result lands.
        e = model_arith(3'd3, 32'd1000, 32'd7);
        sb.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        start = 1'b1; md_op = 3'd3; src_a = 32'd1000; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd7;
        repeat (12) @(posedge clk);
        #1;

        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            if (op <= 3'd3) run_arith(op, rand_word(), rand_word(), 1'($urandom_range(0, 1)));
            else if (op <= 3'd5) run_move(op, $urandom, 1'($urandom_range(0, 1)));
            else run_noop(op);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("illegal_starts", 64'(illegal_starts), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
